// File: rtl/instr_pair_encoder.sv
// instr_pair_encoder: re-encodes decoded RV32I field records into 32-bit
// instruction words, buffers them in a small FIFO and presents them as
// older/younger pairs for the dual-issue instruction memory. A flush pads
// an odd trailing word with a NOP so the last pair can still be written.
module instr_pair_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [11:0]       in_imm12,
  input  logic [19:0]       in_imm20,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr_a,
  output logic [31:0]       out_instr_b,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_op
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [PTR_W:0] CNT_ZERO = '0;
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             flush_pend;

  logic [31:0]      enc_word;
  logic             enc_bad;
  logic             push;
  logic             pop;
  logic [PTR_W:0]   pop_n;
  logic [PTR_W:0]   push_count;
  logic [PTR_W:0]   count_next;
  logic             flush_pend_next;

  // Rebuild the instruction word from its fields; unknown opcodes become a NOP.
  always_comb begin
    enc_word = NOP;
    enc_bad  = 1'b0;
    case (in_op)
      7'h33: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      7'h13,
      7'h03: enc_word = {in_imm12, in_rs1, in_funct3, in_rd, in_op};
      7'h23: enc_word = {in_imm12[11:5], in_rs2, in_rs1, in_funct3,
                         in_imm12[4:0], in_op};
      7'h63: enc_word = {in_imm12[11], in_imm12[9:4], in_rs2, in_rs1, in_funct3,
                         in_imm12[3:0], in_imm12[10], in_op};
      7'h6F: enc_word = {in_imm20[19], in_imm20[9:0], in_imm20[10],
                         in_imm20[18:11], in_rd, in_op};
      default: begin
        enc_word = NOP;
        enc_bad  = 1'b1;
      end
    endcase
  end

  // Handshakes, pairing and next-state bookkeeping, all from registered state.
  // A flush only arms when something (including a same-cycle push) is buffered,
  // and it disarms as soon as the buffer empties.
  always_comb begin
    in_ready        = rst_n && (count < CNT_FULL) && !flush_pend;
    push            = in_valid && in_ready;
    out_valid       = (count >= CNT_TWO) || ((count == CNT_ONE) && flush_pend);
    pop             = out_valid && out_ready;
    pop_n           = CNT_ZERO;
    if (pop) pop_n  = (count >= CNT_TWO) ? CNT_TWO : CNT_ONE;
    push_count      = count + {{PTR_W{1'b0}}, push};
    count_next      = push_count - pop_n;
    flush_pend_next = (flush_pend || (flush && (push_count != CNT_ZERO)))
                      && (count_next != CNT_ZERO);
    out_instr_a     = (count != CNT_ZERO) ? mem[rd_ptr] : NOP;
    out_instr_b     = (count >= CNT_TWO) ? mem[rd_ptr + PTR_W'(1)] : NOP;
  end

  // Storage for encoded words; only the occupied slots are ever read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // Pointers, occupancy, flush state, pair address and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      out_addr   <= '0;
      err_op     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr + pop_n[PTR_W-1:0];
      count      <= count_next;
      flush_pend <= flush_pend_next;
      if (pop) out_addr <= out_addr + ADDR_W'(1);
      err_op     <= push && enc_bad;
    end
  end

endmodule

// File: tb/tb_instr_pair_encoder.sv
// tb_instr_pair_encoder: directed vectors with hand-encoded RV32I words for
// instr_pair_encoder (DEPTH=4, ADDR_W=2 so the pair address wraps quickly).
module tb_instr_pair_encoder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [11:0] in_imm12;
  logic [19:0] in_imm20;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr_a;
  logic [31:0] out_instr_b;
  logic [1:0]  out_addr;
  logic        err_op;

  int num_compared;
  int num_mismatched;

  instr_pair_encoder #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm12(in_imm12), .in_imm20(in_imm20),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr_a(out_instr_a), .out_instr_b(out_instr_b),
    .out_addr(out_addr), .err_op(err_op)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present one record (optionally with a flush pulse) for a single edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [11:0] imm12, input logic [19:0] imm20,
                               input logic do_flush);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm12  = imm12;
    in_imm20  = imm20;
    flush     = do_flush;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_imm12  = '0;
    in_imm20  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset values
    #12;
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_addr", {30'b0, out_addr}, 32'd0);
    checkOutput("rst_a", out_instr_a, NOP);
    checkOutput("rst_b", out_instr_b, NOP);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_err", {31'b0, err_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // add x3,x1,x2 then addi x5,x0,-1
    applyStimulus(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h000, 20'h0, 1'b0);
    checkOutput("single_no_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 20'h0, 1'b0);
    checkOutput("p0_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("p0_a", out_instr_a, 32'h002081B3);
    checkOutput("p0_b", out_instr_b, 32'hFFF00293);
    checkOutput("p0_addr", {30'b0, out_addr}, 32'd0);

    // beq x1,x2,+8 then jal x1,+2048 (first push pops the previous pair)
    applyStimulus(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'h004, 20'h0, 1'b0);
    applyStimulus(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'h000, 20'h00400, 1'b0);
    checkOutput("p1_a", out_instr_a, 32'h00208463);
    checkOutput("p1_b", out_instr_b, 32'h001000EF);
    checkOutput("p1_addr", {30'b0, out_addr}, 32'd1);

    // sw x2,12(x1) with flush in the same cycle: padded pair
    applyStimulus(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'h00C, 20'h0, 1'b1);
    checkOutput("pad_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("pad_a", out_instr_a, 32'h0020A623);
    checkOutput("pad_b", out_instr_b, NOP);
    checkOutput("pad_addr", {30'b0, out_addr}, 32'd2);
    checkOutput("pad_ready_low", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b0;
    waitCycle();
    checkOutput("pad_hold_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("pad_hold_a", out_instr_a, 32'h0020A623);
    out_ready = 1'b1;
    waitCycle();
    checkOutput("pad_popped_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("pad_popped_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("pad_popped_addr", {30'b0, out_addr}, 32'd3);

    // flush with an empty buffer does nothing
    flush = 1'b1;
    waitCycle();
    flush = 1'b0;
    checkOutput("empty_flush_ready", {31'b0, in_ready}, 32'd1);
    waitCycle();
    checkOutput("empty_flush_valid", {31'b0, out_valid}, 32'd0);

    // unsupported opcode
    applyStimulus(7'h7F, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 12'hABC, 20'h12345, 1'b0);
    checkOutput("err_pulse", {31'b0, err_op}, 32'd1);
    waitCycle();
    checkOutput("err_cleared", {31'b0, err_op}, 32'd0);
    applyStimulus(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 20'h0, 1'b0);
    checkOutput("err_word_a", out_instr_a, NOP);
    checkOutput("err_word_b", out_instr_b, 32'hFFF00293);
    checkOutput("err_pair_addr", {30'b0, out_addr}, 32'd3);
    waitCycle();
    checkOutput("addr_wrap", {30'b0, out_addr}, 32'd0);

    // Backpressure: fill the FIFO with out_ready low
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      applyStimulus(7'h33, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h0, 1'b0);
    checkOutput("full_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("full_a", out_instr_a, 32'h000000B3);
    checkOutput("full_b", out_instr_b, 32'h00000133);
    waitCycle();
    waitCycle();
    checkOutput("stall_a", out_instr_a, 32'h000000B3);
    checkOutput("stall_b", out_instr_b, 32'h00000133);
    checkOutput("stall_addr", {30'b0, out_addr}, 32'd0);
    out_ready = 1'b1;
    waitCycle();
    checkOutput("drain_addr", {30'b0, out_addr}, 32'd1);
    checkOutput("drain_a", out_instr_a, 32'h000001B3);
    checkOutput("drain_b", out_instr_b, 32'h00000233);
    checkOutput("drain_ready", {31'b0, in_ready}, 32'd1);
    waitCycle();
    checkOutput("drained_valid", {31'b0, out_valid}, 32'd0);

    // Three more pairs: addresses 2,3,0
    for (int p = 2; p <= 4; p++) begin
      applyStimulus(7'h33, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h0, 1'b0);
      applyStimulus(7'h33, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h0, 1'b0);
      checkOutput($sformatf("seq_addr_%0d", p), {30'b0, out_addr}, 32'(p % 4));
      checkOutput($sformatf("seq_b_%0d", p), out_instr_b, 32'h00000533);
    end
    waitCycle();
    checkOutput("seq_end_addr", {30'b0, out_addr}, 32'd1);

    // Reset with three words buffered and a flush pending
    out_ready = 1'b0;
    applyStimulus(7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h0, 1'b0);
    applyStimulus(7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h0, 1'b0);
    applyStimulus(7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h0, 1'b1);
    checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("pre_rst_ready", {31'b0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_rst_addr", {30'b0, out_addr}, 32'd0);
    checkOutput("mid_rst_b", out_instr_b, NOP);
    checkOutput("mid_rst_a", out_instr_a, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    applyStimulus(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h000, 20'h0, 1'b0);
    checkOutput("post_rst_single", {31'b0, out_valid}, 32'd0);
    applyStimulus(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 20'h0, 1'b0);
    checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("post_rst_addr", {30'b0, out_addr}, 32'd0);
    checkOutput("post_rst_a", out_instr_a, 32'h002081B3);
    checkOutput("post_rst_b", out_instr_b, 32'hFFF00293);
    waitCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/instr_pair_encoder.md
# instr_pair_encoder

Encodes decoded RV32I field records (op, rd, rs1, rs2, funct3, funct7, imm12, imm20) back into 32-bit instruction words and emits them as aligned A/B pairs for the dual-issue fetch path. It is the inverse of the instruction decoder. It feeds instruction-memory preload and bench stimulus: the decoded-field generator drives its input, and its output writes pairs into the dual-issue instruction memory. An internal FIFO decouples one-record-per-cycle input from pair-per-handshake output. An explicit flush pads an odd trailing word with a NOP.

## Interface
- DEPTH, 4: FIFO entries (encoded words); power of two, ≥2
- ADDR_W, 10: width of the pair address counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field record valid
- in_ready  out  1  encoder can accept a record
- in_op  in  7  opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3;  in_funct7  in  7
- in_imm12  in  12  I/S: imm[11:0]; B: imm[12:1]
- in_imm20  in  20  JAL: imm[20:1]
- flush  in  1  single-cycle pulse: emit the pending odd word padded with a NOP
- out_valid  out  1  pair valid
- out_ready  in  1  consumer accepts pair
- out_instr_a / out_instr_b  out  32 each  older / younger word
- out_addr  out  ADDR_W  pair index of the current output
- err_op  out  1  one-cycle pulse: an unsupported opcode was accepted

## Operation
- Encoding applied at acceptance. Fields are written as {bits 31..0}.
  - R (0x33): {f7,rs2,rs1,f3,rd,op}
  - I_IMME (0x13) / LOAD (0x03): {imm12,rs1,f3,rd,op}
  - S (0x23): {imm12[11:5],rs2,rs1,f3,imm12[4:0],op}
  - B (0x63): {imm12[11],imm12[9:4],rs2,rs1,f3,imm12[3:0],imm12[10],op}
  - JAL (0x6F): {imm20[19],imm20[9:0],imm20[10],imm20[18:11],rd,op}
  - Any other opcode: the word becomes NOP 0x00000013 and err_op pulses.
- Unused input fields are ignored. No range checking.
- Accept rule: accept on in_valid && in_ready.
- in_ready = rst_n && count<DEPTH && !flush_pend.
- Pairing:
  - out_instr_a = FIFO head; out_instr_b = head+1.
  - out_valid = count≥2, or count==1 && flush_pend.
  - In the count==1 case, out_instr_b = 0x00000013.
- Pop rule: on out_valid && out_ready, pop 2 entries (or 1 when padded) and increment out_addr by 1.
- out_addr wraps modulo 2^ADDR_W.
- Simultaneous push and pop in one cycle are legal; count updates by (+1 − popped).
- flush:
  - flush while count==0 (after any same-cycle push) is ignored.
  - Otherwise it sets flush_pend.
  - A record accepted in the flush cycle is included in the flushed set.
  - flush_pend clears in the cycle count reaches 0.
  - While flush_pend is set, no new input is accepted. Even counts drain as normal pairs; an odd count ends with a padded pair.
- While out_valid && !out_ready, out_instr_a, out_instr_b and out_addr stay stable.

## Timing
- Reset (rst_n low, async) forces:
  - count=0, pointers=0, flush_pend=0
  - out_valid=0, out_addr=0, err_op=0, in_ready=0
  - out_instr_a/b = 0x00000013
- in_ready rises in the first cycle after deassertion.
- Latency: a record accepted at edge N that completes a pair produces out_valid in the cycle after N. No combinational path from in_valid to out_valid.
- err_op is registered: high for exactly the cycle after the edge that accepted the bad record.
- in_ready has a combinational dependency on out_ready only through count; it uses registered count, with no same-cycle pop credit.
- Throughput: 1 record per cycle in, 1 pair per cycle out.
- Reset mid-operation discards all buffered words and any pending flush.

## Test plan
- Push add x3,x1,x2 (op 0x33, rd 3, rs1 1, rs2 2, f3 0, f7 0), then addi x5,x0,-1 (op 0x13, rd 5, imm12 0xFFF), with out_ready=1. Required: one cycle later out_valid=1, A=0x002081B3, B=0xFFF00293, out_addr=0.
- Push beq x1,x2,+8 (op 0x63, imm12 0x004), then jal x1,+2048 (op 0x6F, rd 1, imm20 0x00400). Required: A=0x00208463, B=0x001000EF.
- Push sw x2,12(x1) (op 0x23, f3 2, imm12 0x00C) and pulse flush in the same cycle. Required: A=0x0020A623, B=0x00000013. in_ready is low until the pair pops, then high.
- Push op 0x7F. Required: err_op=1 for exactly one cycle; the buffered word is 0x00000013.
- With out_ready=0 and DEPTH=4, push 4 records. Required: in_ready=0 after the 4th; outputs hold stable. Then out_ready=1. Required: pairs at out_addr 0 and 1; in_ready returns to 1. With ADDR_W=2, 5 pairs give out_addr 0,1,2,3,0.
- With count=3 and flush_pend=1, drop rst_n. Required: outputs immediately go to reset values (out_valid=0, out_addr=0, B=0x00000013). After release, a fresh pair starts at out_addr 0.
